// File: rtl/phys_reg_pkg.sv
// phys_reg_pkg: shared sizes and types for the physical register file and FRAT/RRAT tables
package phys_reg_pkg;
  localparam int NUM_PHYS_REGS = 64;
  localparam int PHYS_IDX_W = 6;
  localparam int DATA_W = 32;
  typedef logic [PHYS_IDX_W-1:0] phys_idx_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/phys_reg_file_entry.sv
// phys_reg_entry: one physical register with its own write-enable decode
module phys_reg_entry #(
  parameter int DATA_W = 32,
  parameter int IDX_W = 6,
  parameter int INDEX = 0,
  parameter bit HARDWIRED = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              update,
  input  logic [IDX_W-1:0]  reg_to_update,
  input  logic [DATA_W-1:0] new_value,
  output logic [DATA_W-1:0] q
);
  logic we;
  assign we = update && !stall && !HARDWIRED && reg_to_update == IDX_W'(INDEX);
  // clear on reset, otherwise load only when this entry is addressed
  always_ff @(posedge clk)
    if (!reset) q <= '0;
    else if (we) q <= new_value;
endmodule

// File: rtl/phys_reg_file.sv
// phys_reg_file: 64x32 physical register file, one write port, all entries exposed; PHYS_REG_ZERO_EN hardwires entry 0 to zero
module phys_reg_file #(
  parameter int NUM_REGS = phys_reg_pkg::NUM_PHYS_REGS,
  parameter int DATA_W = phys_reg_pkg::DATA_W,
  parameter int IDX_W = phys_reg_pkg::PHYS_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [IDX_W-1:0]  reg_to_update,
  input  logic [DATA_W-1:0] new_value,
  input  logic              update,
  output logic [DATA_W-1:0] regs [NUM_REGS]
);
  import phys_reg_pkg::*;
`ifdef PHYS_REG_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    phys_reg_entry #(
      .DATA_W(DATA_W),
      .IDX_W(IDX_W),
      .INDEX(i),
      .HARDWIRED(ZERO_EN && i == 0)
    ) u_entry (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .update(update),
      .reg_to_update(reg_to_update),
      .new_value(new_value),
      .q(regs[i])
    );
  end
endmodule

// File: tb/tb_phys_reg_file.sv
// tb_phys_reg_file: randomized self-checking bench against an array model of the register file
module tb_phys_reg_file;
  localparam int N = 64;
  localparam int W = 32;
  localparam int IW = 6;
`ifdef PHYS_REG_ZERO_EN
  localparam bit Z = 1'b1;
`else
  localparam bit Z = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, stall, update;
  logic [IW-1:0] reg_to_update;
  logic [W-1:0] new_value;
  logic [W-1:0] regs [N];
  logic [W-1:0] model [N];
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  phys_reg_file dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .reg_to_update(reg_to_update),
    .new_value(new_value),
    .update(update),
    .regs(regs)
  );

  task automatic drive(input logic r, input logic s, input logic u, input int idx, input logic [W-1:0] v);
    reset = r;
    stall = s;
    update = u;
    reg_to_update = idx[IW-1:0];
    new_value = v;
  endtask

  task automatic step();
    if (!reset) foreach (model[i]) model[i] = '0;
    else if (update && !stall && int'(reg_to_update) < N && !(Z && reg_to_update == 0))
      model[reg_to_update] = new_value;
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 1'b1, i, $urandom);
      step();
    end
  endtask

  task automatic test_reset();
    preload();
    drive(1'b0, 1'b0, 1'b1, 7, $urandom);
    step();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (regs[i] !== 32'h0) begin
        fails++;
        $display("FAIL reset idx=%0d got=%h exp=00000000", i, regs[i]);
      end
    end
    preload();
    drive(1'b0, 1'b1, 1'b0, 3, 32'h0);
    step();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (regs[i] !== 32'h0) begin
        fails++;
        $display("FAIL reset_stall idx=%0d got=%h exp=00000000", i, regs[i]);
      end
    end
  endtask

  task automatic test_basic_write();
    logic [W-1:0] old;
    preload();
    old = model[37];
    drive(1'b1, 1'b0, 1'b1, 37, 32'hDEADBEEF);
    #1;
    checks++;
    if (regs[37] !== old) begin
      fails++;
      $display("FAIL pre_edge_old got=%h exp=%h", regs[37], old);
    end
    step();
    checks++;
    if (regs[37] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL basic_write got=%h exp=deadbeef", regs[37]);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (regs[i] !== model[i]) begin
        fails++;
        $display("FAIL basic_others idx=%0d got=%h exp=%h", i, regs[i], model[i]);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 37, 32'h0);
    step();
    checks++;
    if (regs[37] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL basic_persist got=%h exp=deadbeef", regs[37]);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] old;
    drive(1'b1, 1'b0, 1'b1, 5, 32'h0BAD_0005);
    step();
    old = 32'h0BAD_0005;
    drive(1'b1, 1'b1, 1'b1, 5, 32'h12345678);
    step();
    checks++;
    if (regs[5] !== old) begin
      fails++;
      $display("FAIL stall_hold got=%h exp=%h", regs[5], old);
    end
    drive(1'b1, 1'b0, 1'b0, 5, 32'h12345678);
    step();
    checks++;
    if (regs[5] !== old) begin
      fails++;
      $display("FAIL stall_not_queued got=%h exp=%h", regs[5], old);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b1, 63, 32'h1);
    step();
    checks++;
    if (regs[63] !== 32'h1) begin
      fails++;
      $display("FAIL b2b_first got=%h exp=00000001", regs[63]);
    end
    drive(1'b1, 1'b0, 1'b1, 63, 32'h2);
    step();
    checks++;
    if (regs[63] !== 32'h2) begin
      fails++;
      $display("FAIL b2b_second got=%h exp=00000002", regs[63]);
    end
    drive(1'b1, 1'b0, 1'b1, 0, 32'hFFFF_FFFF);
    step();
    checks++;
    if (regs[0] !== (Z ? 32'h0 : 32'hFFFF_FFFF)) begin
      fails++;
      $display("FAIL zero_reg got=%h exp=%h", regs[0], Z ? 32'h0 : 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 1'b0, 1'b1, 10, 32'h5555_1111);
    step();
    drive(1'b0, 1'b0, 1'b1, 10, 32'hA5A5A5A5);
    step();
    checks++;
    if (regs[10] !== 32'h0) begin
      fails++;
      $display("FAIL reset_priority got=%h exp=00000000", regs[10]);
    end
  endtask

  task automatic test_walking();
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 1'b1, i, W'(i + 1));
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 0, 32'h0);
    step();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (regs[i] !== ((Z && i == 0) ? 32'h0 : W'(i + 1))) begin
        fails++;
        $display("FAIL walking idx=%0d got=%h exp=%h", i, regs[i], (Z && i == 0) ? 32'h0 : W'(i + 1));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, N - 1), $urandom);
      step();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (regs[i] !== model[i]) begin
          fails++;
          $display("FAIL random cyc=%0d idx=%0d got=%h exp=%h", c, i, regs[i], model[i]);
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 0, 32'h0);
    step();
    test_reset();
    test_basic_write();
    test_stall();
    test_back_to_back();
    test_reset_priority();
    test_walking();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
